// File: rtl/flag_branch_unit_pkg.sv
// rtl/flag_branch_unit_pkg.sv - shared encodings, FSM states and target helper for the flag/branch unit
package flag_branch_unit_pkg;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_VS = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam logic [1:0] FU_NONE = 2'b00;
  localparam logic [1:0] FU_Z    = 2'b01;
  localparam logic [1:0] FU_RSV  = 2'b10;
  localparam logic [1:0] FU_NZV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_RESOLVE    = 2'd2
  } state_t;

  // PC-relative offsets are in halfwords; the add wraps at 16 bits.
  function automatic logic [15:0] calc_target(input logic        is_reg,
                                              input logic [15:0] pc_plus2,
                                              input logic [8:0]  imm9,
                                              input logic [15:0] reg_tgt);
    logic [15:0] offs;
    offs = {{6{imm9[8]}}, imm9, 1'b0};
    return is_reg ? reg_tgt : (pc_plus2 + offs);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - condition-code evaluation: ccc plus N/Z/V flags to a taken decision
module branch_cond
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | (~z & ~n);
      CC_LE:   taken = n | z;
      CC_VS:   taken = v;
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - architectural N/Z/V flag register and branch resolver with flag-wait FSM
module flag_branch_unit
  import flag_branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  flag_upd,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        ex_flag_pending,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_ccc,
  input  logic        br_is_reg,
  input  logic [15:0] br_pc_plus2,
  input  logic [8:0]  br_imm9,
  input  logic [15:0] br_reg_tgt,
  input  logic        flush,
  output logic        res_valid,
  output logic        res_taken,
  output logic [15:0] res_target,
  output logic [2:0]  flags_q
);

  state_t      state, state_nxt;
  logic [2:0]  cap_ccc;
  logic [15:0] cap_target;
  logic        load_cap;
  logic        load_res;
  logic [15:0] res_target_nxt;
  logic        upd_z, upd_nzv, flags_written;
  logic        eff_n, eff_z, eff_v;
  logic [2:0]  ccc_sel;
  logic        cond_taken;
  logic [15:0] req_target;

  assign upd_z         = (flag_upd == FU_Z) || (flag_upd == FU_NZV);
  assign upd_nzv       = (flag_upd == FU_NZV);
  assign flags_written = upd_z;

  // Forwarding: flags written this cycle are visible to a branch in the same cycle.
  assign eff_n = upd_nzv ? alu_n : flags_q[2];
  assign eff_z = upd_z   ? alu_z : flags_q[1];
  assign eff_v = upd_nzv ? alu_v : flags_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (upd_nzv) begin
      flags_q <= {alu_n, alu_z, alu_v};
    end else if (upd_z) begin
      flags_q[1] <= alu_z;
    end
  end

  assign req_target = calc_target(br_is_reg, br_pc_plus2, br_imm9, br_reg_tgt);
  assign ccc_sel    = (state == ST_IDLE) ? br_ccc : cap_ccc;

  branch_cond u_branch_cond (
    .ccc   (ccc_sel),
    .n     (eff_n),
    .z     (eff_z),
    .v     (eff_v),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_cap       = 1'b0;
    load_res       = 1'b0;
    res_target_nxt = cap_target;
    case (state)
      ST_IDLE: begin
        res_target_nxt = req_target;
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (br_valid) begin
          if (ex_flag_pending && (br_ccc != CC_AL)) begin
            state_nxt = ST_WAIT_FLAGS;
            load_cap  = 1'b1;
          end else begin
            state_nxt = ST_RESOLVE;
            load_res  = 1'b1;
          end
        end
      end
      ST_WAIT_FLAGS: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (flags_written || !ex_flag_pending) begin
          state_nxt = ST_RESOLVE;
          load_res  = 1'b1;
        end
      end
      ST_RESOLVE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_ccc    <= 3'b000;
      cap_target <= 16'h0000;
    end else if (load_cap) begin
      cap_ccc    <= br_ccc;
      cap_target <= req_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_taken  <= 1'b0;
      res_target <= 16'h0000;
    end else if (load_res) begin
      res_taken  <= cond_taken;
      res_target <= res_target_nxt;
    end
  end

  assign br_ready  = (state == ST_IDLE);
  assign res_valid = (state == ST_RESOLVE) && !flush;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed self-checking bench for flag_branch_unit
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  flag_upd;
  logic        alu_n, alu_z, alu_v;
  logic        ex_flag_pending;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_ccc;
  logic        br_is_reg;
  logic [15:0] br_pc_plus2;
  logic [8:0]  br_imm9;
  logic [15:0] br_reg_tgt;
  logic        flush;
  logic        res_valid;
  logic        res_taken;
  logic [15:0] res_target;
  logic [2:0]  flags_q;

  int n_tests = 0;
  int n_fail  = 0;

  flag_branch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flag_upd        (flag_upd),
    .alu_n           (alu_n),
    .alu_z           (alu_z),
    .alu_v           (alu_v),
    .ex_flag_pending (ex_flag_pending),
    .br_valid        (br_valid),
    .br_ready        (br_ready),
    .br_ccc          (br_ccc),
    .br_is_reg       (br_is_reg),
    .br_pc_plus2     (br_pc_plus2),
    .br_imm9         (br_imm9),
    .br_reg_tgt      (br_reg_tgt),
    .flush           (flush),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .flags_q         (flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    flag_upd = 2'b00; alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0;
    ex_flag_pending = 1'b0; br_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic req(input logic [2:0] ccc, input logic is_reg, input logic [15:0] pc,
                     input logic [8:0] imm, input logic [15:0] rt);
    br_valid = 1'b1; br_ccc = ccc; br_is_reg = is_reg;
    br_pc_plus2 = pc; br_imm9 = imm; br_reg_tgt = rt;
  endtask

  // Expected taken per ccc (bit index = ccc) for flag patterns {N,Z,V} = 000, 100, 010, 001
  logic [7:0] cond_exp [4] = '{8'b1001_0101, 8'b1010_1001, 8'b1011_0010, 8'b1101_0101};
  logic [2:0] cond_pat [4] = '{3'b000, 3'b100, 3'b010, 3'b001};

  initial begin
    logic [7:0] row;
    logic [2:0] pat;
    quiet();
    br_ccc = 3'b000; br_is_reg = 1'b0; br_pc_plus2 = 16'h0; br_imm9 = 9'h0; br_reg_tgt = 16'h0;
    rst_n = 1'b0;
    #1;
    chk("rst flags_q", 16'(flags_q), 16'h0);
    chk("rst res_valid", 16'(res_valid), 16'h0);
    chk("rst res_taken", 16'(res_taken), 16'h0);
    chk("rst res_target", res_target, 16'h0000);
    chk("rst br_ready", 16'(br_ready), 16'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // Backward B with negative offset, NE with Z=0
    req(3'b000, 1'b0, 16'h0010, 9'h1FF, 16'h0);
    tick();
    quiet();
    chk("b29 res_valid", 16'(res_valid), 16'h1);
    chk("b29 res_taken", 16'(res_taken), 16'h1);
    chk("b29 res_target", res_target, 16'h000E);
    chk("b29 br_ready busy", 16'(br_ready), 16'h0);
    tick();
    chk("b29 pulse one cycle", 16'(res_valid), 16'h0);
    chk("b29 br_ready back", 16'(br_ready), 16'h1);

    // Same-cycle flag forwarding
    flag_upd = 2'b11; alu_z = 1'b1;
    req(3'b001, 1'b0, 16'h0100, 9'h000, 16'h0);
    tick();
    quiet();
    chk("fwd res_valid", 16'(res_valid), 16'h1);
    chk("fwd res_taken", 16'(res_taken), 16'h1);
    chk("fwd flags_q", 16'(flags_q), 16'h2);
    tick();

    // Z-only update leaves N and V alone; 10 is a no-op
    flag_upd = 2'b11; alu_n = 1'b1; alu_z = 1'b0; alu_v = 1'b0;
    tick();
    chk("nzv load", 16'(flags_q), 16'h4);
    flag_upd = 2'b01; alu_n = 1'b1; alu_z = 1'b1; alu_v = 1'b1;
    tick();
    chk("z only", 16'(flags_q), 16'h6);
    flag_upd = 2'b10; alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0;
    tick();
    chk("upd 10 noop", 16'(flags_q), 16'h6);
    quiet();

    // Wait for pending flags, resolved by forwarded V
    ex_flag_pending = 1'b1;
    req(3'b110, 1'b0, 16'h0200, 9'h004, 16'h0);
    tick();
    br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait br_ready c%0d", i), 16'(br_ready), 16'h0);
      chk($sformatf("wait res_valid c%0d", i), 16'(res_valid), 16'h0);
      tick();
    end
    flag_upd = 2'b11; alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b1; ex_flag_pending = 1'b0;
    tick();
    quiet();
    chk("wait res_valid", 16'(res_valid), 16'h1);
    chk("wait res_taken", 16'(res_taken), 16'h1);
    chk("wait res_target", res_target, 16'h0208);
    chk("wait flags_q", 16'(flags_q), 16'h1);
    tick();

    // Wait resolved from flags_q when pending drops with no update
    ex_flag_pending = 1'b1;
    req(3'b001, 1'b0, 16'h0300, 9'h100, 16'h0);
    tick();
    br_valid = 1'b0;
    tick();
    chk("wait2 holding", 16'(res_valid), 16'h0);
    ex_flag_pending = 1'b0;
    tick();
    chk("wait2 res_valid", 16'(res_valid), 16'h1);
    chk("wait2 res_taken", 16'(res_taken), 16'h0);
    chk("wait2 res_target", res_target, 16'h0100);
    tick();

    // Target wrap and register branch (AL bypasses the pending wait)
    req(3'b111, 1'b0, 16'hFFFE, 9'h002, 16'h0);
    tick();
    quiet();
    chk("wrap res_taken", 16'(res_taken), 16'h1);
    chk("wrap res_target", res_target, 16'h0002);
    tick();
    ex_flag_pending = 1'b1;
    req(3'b111, 1'b1, 16'h0040, 9'h010, 16'h1234);
    tick();
    quiet();
    chk("br res_valid", 16'(res_valid), 16'h1);
    chk("br res_taken", 16'(res_taken), 16'h1);
    chk("br res_target", res_target, 16'h1234);
    tick();

    // Flush while waiting
    ex_flag_pending = 1'b1;
    req(3'b000, 1'b0, 16'h0500, 9'h000, 16'h0);
    tick();
    br_valid = 1'b0;
    chk("fl wait br_ready", 16'(br_ready), 16'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; ex_flag_pending = 1'b0;
    chk("fl wait br_ready after", 16'(br_ready), 16'h1);
    chk("fl wait res_valid", 16'(res_valid), 16'h0);
    tick();
    chk("fl wait no late pulse", 16'(res_valid), 16'h0);

    // Flush in the resolve cycle suppresses the pulse
    req(3'b111, 1'b0, 16'h0600, 9'h000, 16'h0);
    tick();
    br_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl resolve res_valid", 16'(res_valid), 16'h0);
    tick();
    flush = 1'b0;
    chk("fl resolve br_ready", 16'(br_ready), 16'h1);

    // Flush beats br_valid; flags still update under flush
    flush = 1'b1; flag_upd = 2'b11; alu_n = 1'b1; alu_z = 1'b1; alu_v = 1'b0;
    req(3'b111, 1'b0, 16'h0700, 9'h000, 16'h0);
    tick();
    quiet();
    chk("fl prio res_valid", 16'(res_valid), 16'h0);
    chk("fl prio br_ready", 16'(br_ready), 16'h1);
    chk("fl flags_q", 16'(flags_q), 16'h6);

    // Reset while waiting drops the branch
    ex_flag_pending = 1'b1;
    req(3'b000, 1'b0, 16'h0800, 9'h000, 16'h0);
    tick();
    br_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst mid flags_q", 16'(flags_q), 16'h0);
    chk("rst mid br_ready", 16'(br_ready), 16'h1);
    tick();
    rst_n = 1'b1; ex_flag_pending = 1'b0;
    tick();
    chk("rst mid no pulse 1", 16'(res_valid), 16'h0);
    tick();
    chk("rst mid no pulse 2", 16'(res_valid), 16'h0);

    // Condition table with forwarded flags
    for (int p = 0; p < 4; p++) begin
      row = cond_exp[p];
      pat = cond_pat[p];
      for (int c = 0; c < 8; c++) begin
        flag_upd = 2'b11; alu_n = pat[2]; alu_z = pat[1]; alu_v = pat[0];
        req(3'(c), 1'b0, 16'h0000, 9'h000, 16'h0);
        tick();
        quiet();
        chk($sformatf("cond p%0d c%0d", p, c), 16'(res_taken), 16'(row[c]));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
